// File: rtl/pifo_calendar.sv
// Root-only PIFO calendar: a rank-sorted array of descriptors with insert, pop-head and occupancy.
// Optional macro PIFO_CALENDAR_GATE_EN: pop only when head rank <= s_axis_global_pifo.
module pifo_calendar #(
  parameter int PIFO_CALENDAR_SIZE        = 10,
  parameter int BUFFER_ADDR_WIDTH         = 12,
  parameter int PIFO_CALENDAR_INDEX_WIDTH = 32,
  parameter int PIFO_INFO_WIDTH           = 32
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [PIFO_INFO_WIDTH-1:0]           s_axis_pifo_info_root,
  input  logic                                 s_axis_insert_en,
  input  logic                                 s_axis_pop_en,
  input  logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] s_axis_global_pifo,
  output logic [PIFO_INFO_WIDTH-1:0]           m_axis_pifo_calendar_top,
  output logic [BUFFER_ADDR_WIDTH-1:0]         m_axis_buffer_addr,
  output logic                                 m_axis_calendar_full,
  output logic [PIFO_CALENDAR_INDEX_WIDTH-1:0] m_axis_calendar_count
);

  localparam int RANK_W = PIFO_INFO_WIDTH - BUFFER_ADDR_WIDTH;
  localparam int CNT_W  = $clog2(PIFO_CALENDAR_SIZE + 1);
  localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(PIFO_CALENDAR_SIZE);

  function automatic logic [RANK_W-1:0] rank_of(input logic [PIFO_INFO_WIDTH-1:0] d);
    return d[PIFO_INFO_WIDTH-1:BUFFER_ADDR_WIDTH];
  endfunction

  logic [PIFO_INFO_WIDTH-1:0]   entry_r [PIFO_CALENDAR_SIZE];
  logic [PIFO_INFO_WIDTH-1:0]   base_s  [PIFO_CALENDAR_SIZE];
  logic [PIFO_INFO_WIDTH-1:0]   next_s  [PIFO_CALENDAR_SIZE];
  logic [CNT_W-1:0]             count_r;
  logic [CNT_W-1:0]             base_count_s;
  logic [CNT_W-1:0]             next_count_s;
  logic [CNT_W-1:0]             pos_s;
  logic                         full_r;
  logic [BUFFER_ADDR_WIDTH-1:0] addr_r;
  logic                         gate_s;
  logic                         pop_ok_s;
  logic                         ins_ok_s;

`ifdef PIFO_CALENDAR_GATE_EN
  assign gate_s = ({{PIFO_CALENDAR_INDEX_WIDTH{1'b0}}, rank_of(entry_r[0])} <=
                   {{RANK_W{1'b0}}, s_axis_global_pifo});
`else
  logic unused_global;
  assign unused_global = ^s_axis_global_pifo;
  assign gate_s = 1'b1;
`endif

  assign pop_ok_s = s_axis_pop_en && (count_r != {CNT_W{1'b0}}) && gate_s;

  // Pop stage: remove the head first so a same-cycle insert sorts among the survivors.
  always_comb begin
    base_count_s = count_r;
    for (int i = 0; i < PIFO_CALENDAR_SIZE; i++) base_s[i] = entry_r[i];
    if (pop_ok_s) begin
      base_count_s = count_r - CNT_W'(1);
      for (int i = 0; i < PIFO_CALENDAR_SIZE - 1; i++) base_s[i] = entry_r[i+1];
      base_s[PIFO_CALENDAR_SIZE-1] = {PIFO_INFO_WIDTH{1'b0}};
    end else begin
      base_count_s = count_r;
    end
  end

  // Insert stage: slot = number of valid entries with rank <= new rank, which keeps ties FIFO.
  always_comb begin
    ins_ok_s     = s_axis_insert_en && (base_count_s < SIZE_C);
    pos_s        = {CNT_W{1'b0}};
    next_count_s = base_count_s;
    for (int i = 0; i < PIFO_CALENDAR_SIZE; i++) next_s[i] = base_s[i];
    for (int i = 0; i < PIFO_CALENDAR_SIZE; i++) begin
      if ((CNT_W'(i) < base_count_s) &&
          (rank_of(base_s[i]) <= rank_of(s_axis_pifo_info_root))) begin
        pos_s = pos_s + CNT_W'(1);
      end else begin
        pos_s = pos_s;
      end
    end
    if (ins_ok_s) begin
      next_count_s = base_count_s + CNT_W'(1);
      next_s[0] = (pos_s == {CNT_W{1'b0}}) ? s_axis_pifo_info_root : base_s[0];
      for (int i = 1; i < PIFO_CALENDAR_SIZE; i++) begin
        if (CNT_W'(i) < pos_s) begin
          next_s[i] = base_s[i];
        end else if (CNT_W'(i) == pos_s) begin
          next_s[i] = s_axis_pifo_info_root;
        end else begin
          next_s[i] = base_s[i-1];
        end
      end
    end else begin
      next_count_s = base_count_s;
    end
  end

  // State and output registers; invalid slots are always held at zero so entry 0 doubles as top.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PIFO_CALENDAR_SIZE; i++) entry_r[i] <= {PIFO_INFO_WIDTH{1'b0}};
      count_r <= {CNT_W{1'b0}};
      full_r  <= 1'b0;
      addr_r  <= {BUFFER_ADDR_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < PIFO_CALENDAR_SIZE; i++) entry_r[i] <= next_s[i];
      count_r <= next_count_s;
      full_r  <= (next_count_s == SIZE_C);
      if (pop_ok_s) addr_r <= entry_r[0][BUFFER_ADDR_WIDTH-1:0];
    end
  end

  assign m_axis_pifo_calendar_top = entry_r[0];
  assign m_axis_buffer_addr       = addr_r;
  assign m_axis_calendar_full     = full_r;
  assign m_axis_calendar_count    = PIFO_CALENDAR_INDEX_WIDTH'(count_r);

endmodule

// File: tb/tb_pifo_calendar.sv
// Randomized bench for pifo_calendar against a queue-based reference of the rank-ordered calendar.
module tb_pifo_calendar;

  localparam int SIZE = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] info = 32'd0;
  logic        ins = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] glob = 32'd0;
  logic [31:0] top;
  logic [11:0] baddr;
  logic        full;
  logic [31:0] count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q[$];
  logic [11:0] m_addr = 12'd0;

  pifo_calendar dut (
    .clk                     (clk),
    .rstn                    (rstn),
    .s_axis_pifo_info_root   (info),
    .s_axis_insert_en        (ins),
    .s_axis_pop_en           (pop),
    .s_axis_global_pifo      (glob),
    .m_axis_pifo_calendar_top(top),
    .m_axis_buffer_addr      (baddr),
    .m_axis_calendar_full    (full),
    .m_axis_calendar_count   (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [19:0] rk(input logic [31:0] d);
    return d[31:12];
  endfunction

  task automatic model_update(input logic i_ins, input logic i_pop,
                              input logic [31:0] i_info, input logic [31:0] i_glob);
    bit gate_ok;
    int k;
`ifdef PIFO_CALENDAR_GATE_EN
    gate_ok = (q.size() > 0) && ({12'd0, rk(q[0])} <= i_glob);
`else
    gate_ok = 1'b1;
`endif
    if (i_pop && q.size() > 0 && gate_ok) begin
      m_addr = q[0][11:0];
      void'(q.pop_front());
    end
    if (i_ins && q.size() < SIZE) begin
      k = 0;
      while (k < q.size() && rk(q[k]) <= rk(i_info)) k++;
      q.insert(k, i_info);
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, "_top"}, {32'd0, top}, {32'd0, (q.size() > 0) ? q[0] : 32'd0});
    check_eq({tag, "_count"}, {32'd0, count}, 64'(q.size()));
    check_eq({tag, "_full"}, {63'd0, full}, {63'd0, q.size() == SIZE});
    check_eq({tag, "_addr"}, {52'd0, baddr}, {52'd0, m_addr});
  endtask

  task automatic step(input string tag, input logic i_ins, input logic i_pop,
                      input logic [31:0] i_info, input logic [31:0] i_glob);
    @(negedge clk);
    ins = i_ins; pop = i_pop; info = i_info; glob = i_glob;
    model_update(i_ins, i_pop, i_info, i_glob);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  function automatic logic [31:0] mk(input int r, input int a);
    return {20'(r), 12'(a)};
  endfunction

  initial begin
    logic [31:0] saved_top;
    logic [11:0] saved_addr;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    rstn = 1'b1;
    step("idle", 1'b0, 1'b0, 32'd0, 32'd0);

    // basic sort and pop order
    step("ins5", 1'b1, 1'b0, mk(5, 5), 32'hFFFF_FFFF);
    step("ins3", 1'b1, 1'b0, mk(3, 3), 32'hFFFF_FFFF);
    step("ins9", 1'b1, 1'b0, mk(9, 9), 32'hFFFF_FFFF);
    check_eq("tp_top", {32'd0, top}, {32'd0, 32'h0000_3003});
    step("pop1", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
    check_eq("tp_pop1", {52'd0, baddr}, 64'h003);
    step("pop2", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
    check_eq("tp_pop2", {52'd0, baddr}, 64'h005);
    step("pop3", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
    check_eq("tp_pop3", {52'd0, baddr}, 64'h009);
    check_eq("tp_empty", {32'd0, count}, 64'd0);

    // fill, drop when full
    for (int i = 0; i < SIZE; i++)
      step("fill", 1'b1, 1'b0, mk($urandom_range(1, 50), 16 + i), 32'hFFFF_FFFF);
    check_eq("tp_full", {63'd0, full}, 64'd1);
    check_eq("tp_cnt10", {32'd0, count}, 64'd10);
    saved_top = top;
    step("drop", 1'b1, 1'b0, mk(0, 12'h777), 32'hFFFF_FFFF);
    check_eq("tp_drop_cnt", {32'd0, count}, 64'd10);
    check_eq("tp_drop_top", {32'd0, top}, {32'd0, saved_top});

    // full: pop and insert a new smallest rank together
    saved_addr = top[11:0];
    step("swap", 1'b1, 1'b1, mk(0, 12'hABC), 32'hFFFF_FFFF);
    check_eq("tp_swap_cnt", {32'd0, count}, 64'd10);
    check_eq("tp_swap_addr", {52'd0, baddr}, {52'd0, saved_addr});
    check_eq("tp_swap_top", {32'd0, top}, 64'h0000_0ABC);
    for (int i = 0; i < SIZE; i++) step("drain", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);

    // equal-rank FIFO order and pop on empty
    step("tie1", 1'b1, 1'b0, mk(7, 1), 32'hFFFF_FFFF);
    step("tie2", 1'b1, 1'b0, mk(7, 2), 32'hFFFF_FFFF);
    step("tiep1", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
    check_eq("tp_tie1", {52'd0, baddr}, 64'h001);
    step("tiep2", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
    check_eq("tp_tie2", {52'd0, baddr}, 64'h002);
    step("pope", 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFF);
    check_eq("tp_pope_addr", {52'd0, baddr}, 64'h002);
    check_eq("tp_pope_cnt", {32'd0, count}, 64'd0);

`ifdef PIFO_CALENDAR_GATE_EN
    step("g_ins", 1'b1, 1'b0, mk(100, 12'h064), 32'd0);
    step("g_99", 1'b0, 1'b1, 32'd0, 32'd99);
    check_eq("tp_gate99", {32'd0, count}, 64'd1);
    step("g_100", 1'b0, 1'b1, 32'd0, 32'd100);
    check_eq("tp_gate100", {32'd0, count}, 64'd0);
    check_eq("tp_gate_addr", {52'd0, baddr}, 64'h064);
`endif

    // randomized traffic with a mid-run asynchronous reset
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] r_info;
      r_info = ($urandom_range(0, 3) == 0) ? $urandom() : mk($urandom_range(0, 15), $urandom_range(0, 4095));
      step("rnd", 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
           r_info, 32'($urandom_range(0, 20)));
      if (c == 700) begin
        @(negedge clk);
        ins = 1'b1; pop = 1'b1; info = mk(1, 1);
        #2;
        rstn = 1'b0;
        #1;
        q.delete();
        m_addr = 12'd0;
        compare_all("async_rst");
        @(posedge clk);
        #1;
        compare_all("rst_hold");
        @(negedge clk);
        ins = 1'b0; pop = 1'b0;
        rstn = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
